// File: rtl/rfm_scheduler_if.sv
// Controller/arbiter side of the RFM scheduler: ACT strobes in, RFM request/grant,
// one-hot RFM command pulses and per-bank ACT blocking out.
interface rfm_scheduler_if #(
   parameter int unsigned NUM_BANK  = 4,
   parameter int unsigned BANK_BITS = 2
);
   logic                 act_cmd;
   logic [BANK_BITS-1:0] act_bank;
   logic                 rfm_req;
   logic [BANK_BITS-1:0] rfm_bank;
   logic                 rfm_gnt;
   logic [NUM_BANK-1:0]  rfm_cmd;
   logic [NUM_BANK-1:0]  act_block;

   modport master (
      output act_cmd, act_bank, rfm_gnt,
      input  rfm_req, rfm_bank, rfm_cmd, act_block
   );

   modport slave (
      input  act_cmd, act_bank, rfm_gnt,
      output rfm_req, rfm_bank, rfm_cmd, act_block
   );
endinterface

// File: rtl/rfm_scheduler.sv
// Per-bank rolling activation accounting with round-robin RFM request/grant scheduling.
// Banks at RFM_TH become pending; banks at RAA_MAX block further ACTs.
module rfm_scheduler #(
   parameter int unsigned NUM_BANK  = 4,
   parameter int unsigned BANK_BITS = 2,
   parameter int unsigned RFM_TH    = 8,
   parameter int unsigned RAA_MAX   = 24,
   parameter int unsigned RAA_SIZE  = 8
) (
   input logic             clk,
   input logic             rstn,
   rfm_scheduler_if.slave  bus
);

   localparam logic [RAA_SIZE-1:0]  TH_V   = RAA_SIZE'(RFM_TH);
   localparam logic [RAA_SIZE-1:0]  MAX_V  = RAA_SIZE'(RAA_MAX);
   localparam logic [BANK_BITS-1:0] LAST_B = BANK_BITS'(NUM_BANK - 1);

   typedef enum logic [1:0] {IDLE, REQ, ISSUE} state_t;

   state_t               state;
   logic [RAA_SIZE-1:0]  raa     [NUM_BANK];
   logic [RAA_SIZE-1:0]  raa_nxt [NUM_BANK];
   logic [NUM_BANK-1:0]  pending;
   logic [NUM_BANK-1:0]  block_nxt;
   logic [BANK_BITS-1:0] rr_ptr;
   logic [BANK_BITS-1:0] sel_bank;
   logic [BANK_BITS-1:0] next_ptr;
   logic                 sel_valid;
   logic                 grant;

   // A grant only counts while a request is actually outstanding.
   assign grant    = (state == REQ) && bus.rfm_gnt;
   assign next_ptr = (bus.rfm_bank == LAST_B) ? '0 : bus.rfm_bank + BANK_BITS'(1);

   always_comb begin
      pending = '0;
      for (int unsigned b = 0; b < NUM_BANK; b++) begin
         pending[b] = (raa[b] >= TH_V);
      end
   end

   // Grant decrement first (floor 0), then ACT increment saturating at RAA_MAX.
   always_comb begin
      block_nxt = '0;
      for (int unsigned b = 0; b < NUM_BANK; b++) begin
         raa_nxt[b] = raa[b];
         if (grant && (bus.rfm_bank == BANK_BITS'(b))) begin
            raa_nxt[b] = (raa[b] >= TH_V) ? raa[b] - TH_V : '0;
         end
         if (bus.act_cmd && (bus.act_bank == BANK_BITS'(b)) && (raa_nxt[b] < MAX_V)) begin
            raa_nxt[b] = raa_nxt[b] + RAA_SIZE'(1);
         end
         block_nxt[b] = (raa_nxt[b] >= MAX_V);
      end
   end

   // Round-robin pick: first pending bank at or above rr_ptr, wrapping.
   always_comb begin
      logic [BANK_BITS-1:0] idx;
      idx       = '0;
      sel_valid = 1'b0;
      sel_bank  = '0;
      for (int unsigned i = 0; i < NUM_BANK; i++) begin
         idx = BANK_BITS'((int'(rr_ptr) + i) % NUM_BANK);
         if (!sel_valid && pending[idx]) begin
            sel_valid = 1'b1;
            sel_bank  = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         bus.rfm_req   <= 1'b0;
         bus.rfm_bank  <= '0;
         bus.rfm_cmd   <= '0;
         bus.act_block <= '0;
         for (int unsigned b = 0; b < NUM_BANK; b++) begin
            raa[b] <= '0;
         end
      end else begin
         raa           <= raa_nxt;
         bus.act_block <= block_nxt;
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  bus.rfm_bank <= sel_bank;
                  bus.rfm_req  <= 1'b1;
                  state        <= REQ;
               end
            end
            REQ: begin
               if (bus.rfm_gnt) begin
                  bus.rfm_req <= 1'b0;
                  bus.rfm_cmd <= NUM_BANK'(1) << bus.rfm_bank;
                  rr_ptr      <= next_ptr;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               bus.rfm_cmd <= '0;
               state       <= IDLE;
            end
            default: begin
               bus.rfm_req <= 1'b0;
               bus.rfm_cmd <= '0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rfm_scheduler.sv
// Self-checking bench for rfm_scheduler: vector table, directed corner sequences and
// randomized traffic against a behavioural model of the RAA/RFM rules.
module tb_rfm_scheduler;

   localparam int NB   = 4;
   localparam int BB   = 2;
   localparam int TH   = 8;
   localparam int RMAX = 24;

   logic clk;
   logic rstn;

   rfm_scheduler_if #(.NUM_BANK(NB), .BANK_BITS(BB)) bus ();

   rfm_scheduler #(
      .NUM_BANK(NB), .BANK_BITS(BB), .RFM_TH(TH), .RAA_MAX(RMAX), .RAA_SIZE(8)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: counters as plain ints, an outstanding request flag, and the bank
   // whose RFM pulse occupies the current cycle (-1 when none).
   int m_raa [NB];
   bit m_req;
   int m_bank;
   int m_cmd;
   int m_rr;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_cmd_vec();
      return (m_cmd < 0) ? 0 : (1 << m_cmd);
   endfunction

   function automatic int m_blk_vec();
      int v = 0;
      for (int b = 0; b < NB; b++) if (m_raa[b] >= RMAX) v |= (1 << b);
      return v;
   endfunction

   task automatic model_edge(input bit r, input bit a, input int ab, input bit g);
      int  nraa [NB];
      bit  granted;
      if (!r) begin
         for (int b = 0; b < NB; b++) m_raa[b] = 0;
         m_req = 0; m_bank = 0; m_cmd = -1; m_rr = 0;
         return;
      end
      for (int b = 0; b < NB; b++) nraa[b] = m_raa[b];
      granted = m_req && g;
      if (granted) nraa[m_bank] = (nraa[m_bank] > TH) ? nraa[m_bank] - TH : 0;
      if (a) nraa[ab] = (nraa[ab] + 1 > RMAX) ? RMAX : nraa[ab] + 1;
      if (m_cmd >= 0) begin
         m_cmd = -1;
      end else if (granted) begin
         m_cmd = m_bank;
         m_req = 0;
         m_rr  = (m_bank + 1) % NB;
      end else if (!m_req) begin
         for (int i = 0; i < NB; i++) begin
            int b = (m_rr + i) % NB;
            if (!m_req && m_raa[b] >= TH) begin
               m_req  = 1;
               m_bank = b;
            end
         end
      end
      for (int b = 0; b < NB; b++) m_raa[b] = nraa[b];
   endtask

   task automatic step(input bit r, input bit a, input int ab, input bit g);
      int cmdv;
      rstn         = r;
      bus.act_cmd  = a;
      bus.act_bank = BB'(ab);
      bus.rfm_gnt  = g;
      @(posedge clk);
      model_edge(r, a, ab, g);
      #1;
      cmdv = int'(bus.rfm_cmd);
      check("rfm_req",   int'(bus.rfm_req),   int'(m_req));
      check("rfm_bank",  int'(bus.rfm_bank),  m_bank);
      check("rfm_cmd",   cmdv,                m_cmd_vec());
      check("act_block", int'(bus.act_block), m_blk_vec());
      check("cmd_onehot0", int'((cmdv & (cmdv - 1)) == 0), 1);
      check("cmd_vs_req",  int'((cmdv != 0) && bus.rfm_req), 0);
   endtask

   typedef struct {
      bit r; bit a; int ab; bit g;
      bit e_req; int e_bank; int e_cmd; int e_blk;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit r, bit a, int ab, bit g, bit er, int eb, int ec, int ek);
      vec_t v;
      v.r = r; v.a = a; v.ab = ab; v.g = g;
      v.e_req = er; v.e_bank = eb; v.e_cmd = ec; v.e_blk = ek;
      tbl.push_back(v);
   endfunction

   initial begin
      int pulses[$];
      int pulse_cyc[$];

      rstn = 1'b0; bus.act_cmd = 1'b0; bus.act_bank = '0; bus.rfm_gnt = 1'b0;
      m_req = 0; m_bank = 0; m_cmd = -1; m_rr = 0;
      for (int b = 0; b < NB; b++) m_raa[b] = 0;

      // Table: 8 ACTs to bank 1 with grant tied high, then refill to check raa[1] went to 0.
      add(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) add(1, 1, 1, 1, 0, 0, 0, 0);
      add(1, 0, 0, 1, 1, 1, 0, 0);
      add(1, 0, 0, 1, 0, 1, 2, 0);
      add(1, 0, 0, 1, 0, 1, 0, 0);
      add(1, 0, 0, 1, 0, 1, 0, 0);
      for (int k = 0; k < 7; k++) add(1, 1, 1, 1, 0, 1, 0, 0);
      add(1, 0, 0, 1, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1, 1, 0, 0);
      add(1, 0, 0, 1, 0, 1, 2, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0);
      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].a, tbl[i].ab, tbl[i].g);
         check($sformatf("tbl%0d_req", i),  int'(bus.rfm_req),   int'(tbl[i].e_req));
         check($sformatf("tbl%0d_bank", i), int'(bus.rfm_bank),  tbl[i].e_bank);
         check($sformatf("tbl%0d_cmd", i),  int'(bus.rfm_cmd),   tbl[i].e_cmd);
         check($sformatf("tbl%0d_blk", i),  int'(bus.act_block), tbl[i].e_blk);
      end

      // Saturation and blocking on bank 2 with grant withheld.
      step(0, 0, 0, 0);
      for (int k = 1; k <= 24; k++) begin
         step(1, 1, 2, 0);
         if (k >= 9) begin
            check("sat_req_held", int'(bus.rfm_req), 1);
            check("sat_bank2",    int'(bus.rfm_bank), 2);
         end
         if (k == 23) check("sat_blk_23", int'(bus.act_block), 0);
         if (k == 24) check("sat_blk_24", int'(bus.act_block), 4);
      end
      step(1, 1, 2, 0);
      check("sat_blk_25", int'(bus.act_block), 4);
      step(1, 0, 0, 1);
      check("sat_gnt_cmd", int'(bus.rfm_cmd), 4);
      check("sat_gnt_blk", int'(bus.act_block), 0);
      for (int n = 0; n < 2; n++) begin
         step(1, 0, 0, 0);
         step(1, 0, 0, 0);
         check("sat_rereq", int'(bus.rfm_req), 1);
         check("sat_rebank", int'(bus.rfm_bank), 2);
         step(1, 0, 0, 1);
         check("sat_recmd", int'(bus.rfm_cmd), 4);
      end
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 0, 0);
         check("sat_drained", int'(bus.rfm_req), 0);
      end

      // Round-robin order across banks 0, 1, 3.
      step(0, 0, 0, 0);
      for (int k = 0; k < 8; k++) step(1, 1, 0, 0);
      for (int k = 0; k < 8; k++) step(1, 1, 1, 0);
      for (int k = 0; k < 8; k++) step(1, 1, 3, 0);
      for (int c = 0; c < 20; c++) begin
         step(1, 0, 0, 1);
         if (bus.rfm_cmd != '0) begin
            pulses.push_back(int'(bus.rfm_cmd));
            pulse_cyc.push_back(c);
         end
      end
      check("rr_count", pulses.size(), 3);
      if (pulses.size() == 3) begin
         check("rr_first",  pulses[0], 1);
         check("rr_second", pulses[1], 2);
         check("rr_third",  pulses[2], 8);
         check("rr_gap01", int'(pulse_cyc[1] - pulse_cyc[0] >= 2), 1);
         check("rr_gap12", int'(pulse_cyc[2] - pulse_cyc[1] >= 2), 1);
      end

      // ACT and grant on the same edge for the same bank.
      step(0, 0, 0, 0);
      for (int k = 0; k < 8; k++) step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      check("same_req", int'(bus.rfm_req), 1);
      step(1, 1, 0, 1);
      check("same_cmd", int'(bus.rfm_cmd), 1);
      step(1, 0, 0, 0);
      for (int k = 0; k < 6; k++) step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("same_raa7_noreq", int'(bus.rfm_req), 0);
      step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      check("same_raa8_req", int'(bus.rfm_req), 1);
      check("same_raa8_bank", int'(bus.rfm_bank), 0);

      // Reset while a request is outstanding.
      step(0, 0, 0, 0);
      for (int k = 0; k < 8; k++) step(1, 1, 1, 0);
      step(1, 0, 0, 0);
      check("rst_pre_req", int'(bus.rfm_req), 1);
      step(0, 1, 1, 1);
      check("rst_req", int'(bus.rfm_req), 0);
      check("rst_cmd", int'(bus.rfm_cmd), 0);
      check("rst_bank", int'(bus.rfm_bank), 0);
      for (int k = 0; k < 5; k++) begin
         step(1, 0, 0, 1);
         check("rst_no_cmd", int'(bus.rfm_cmd), 0);
         check("rst_no_req", int'(bus.rfm_req), 0);
      end
      for (int k = 0; k < 8; k++) step(1, 1, 3, 0);
      step(1, 0, 0, 0);
      check("rst_restart_req", int'(bus.rfm_req), 1);
      check("rst_restart_bank", int'(bus.rfm_bank), 3);

      // Randomized traffic: generous grants first, then starved grants to reach saturation.
      step(0, 0, 0, 0);
      for (int c = 0; c < 4000; c++) begin
         bit r, a, g;
         int ab;
         r  = ($urandom_range(0, 299) != 0);
         a  = ($urandom_range(0, 9) < 6);
         ab = $urandom_range(0, NB - 1);
         g  = (c < 2000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
         step(r, a, ab, g);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rfm_scheduler.md
RFM_SCHEDULER -- requirements
Module: rfm_scheduler

Interface
REQ-001 Parameter NUM_BANK, default 4: number of banks scheduled; one rfm_unit_bank instance per bank.
REQ-002 Parameter BANK_BITS, default 2: log2(NUM_BANK).
REQ-003 Parameter RFM_TH, default 8: RAA level at which a bank becomes RFM-pending; amount subtracted per issued RFM.
REQ-004 Parameter RAA_MAX, default 24: RAA saturation level; ACT blocking threshold; RAA_MAX >= RFM_TH.
REQ-005 Parameter RAA_SIZE, default 8: RAA counter width; 2^RAA_SIZE > RAA_MAX.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rstn  input  1  reset, synchronous, active-low.
REQ-008 act_cmd  input  1  one-cycle ACT strobe from the controller.
REQ-009 act_bank  input  BANK_BITS  target bank of act_cmd; valid only when act_cmd=1.
REQ-010 rfm_req  output  1  RFM slot request to the command arbiter.
REQ-011 rfm_bank  output  BANK_BITS  bank of the outstanding request; stable while rfm_req=1.
REQ-012 rfm_gnt  input  1  arbiter accepts the request; meaningful only while rfm_req=1.
REQ-013 rfm_cmd  output  NUM_BANK  one-hot, one-cycle pulse driving rfm_cmd of the selected rfm_unit_bank.
REQ-014 act_block  output  NUM_BANK  bit b=1: controller must not issue ACT to bank b.

Function
REQ-015 Per-bank RAA counter raa[b], RAA_SIZE bits, unsigned.
REQ-016 act_cmd=1 at an edge: raa[act_bank] increments by 1, saturating at RAA_MAX.
REQ-017 pending[b] = (raa[b] >= RFM_TH); act_block[b] = (raa[b] >= RAA_MAX); both decoded from registered raa, no input combinational path.
REQ-018 FSM states IDLE, REQ, ISSUE; reset state IDLE.
REQ-019 IDLE: if any pending bit set at an edge, select bank by round-robin starting at rr_ptr, searching upward with wrap; latch it into rfm_bank, set rfm_req=1, go REQ; else stay IDLE.
REQ-020 REQ: rfm_req and rfm_bank held; edge with rfm_gnt=1: rfm_req<=0, rfm_cmd[rfm_bank]<=1, raa[rfm_bank] decremented by RFM_TH (floor 0), rr_ptr<=rfm_bank+1 mod NUM_BANK, go ISSUE.
REQ-021 ISSUE: lasts exactly one cycle; rfm_cmd<=0 at its end edge; go IDLE; no new selection during ISSUE.
REQ-022 Latency: pending visible in IDLE at edge N -> rfm_req=1 from cycle N+1; grant sampled at edge G -> rfm_cmd high for cycle G+1 only; next rfm_req earliest at G+2 edge.
REQ-023 rfm_gnt=1 outside REQ is ignored.
REQ-024 ACT and grant same edge, same bank: raa = max(raa - RFM_TH, 0) + 1, then saturation at RAA_MAX.
REQ-025 ACT to a blocked bank (protocol violation): counter stays at RAA_MAX, no other effect.
REQ-026 Selected bank's pending bit cannot clear while in REQ (only grants decrement), so request is never withdrawn.
REQ-027 rfm_cmd has at most one bit set in any cycle; never set while rfm_req=1.

Reset
REQ-028 rstn=0 at an edge, from any state: all raa=0, rr_ptr=0, state IDLE, rfm_req=0, rfm_bank=0, rfm_cmd=0, act_block=0 from the next cycle.
REQ-029 Reset mid-REQ or mid-ISSUE abandons the operation; no rfm_cmd pulse after reset.
REQ-030 act_cmd and rfm_gnt ignored on edges where rstn=0.

Verification
REQ-031 8 ACTs to bank 1, rfm_gnt tied 1 -> rfm_req high 1 cycle after 8th ACT, rfm_bank=1, rfm_cmd=4'b0010 one cycle, raa[1]=0.
REQ-032 24 ACTs to bank 2, rfm_gnt=0 -> rfm_req held with rfm_bank=2 throughout; act_block=4'b0100 after 24th ACT; 25th ACT leaves raa[2]=24; grant -> raa[2]=16, act_block=0.
REQ-033 Banks 0,1,3 each at 8, rr_ptr=0, gnt always 1 -> rfm_cmd pulses in order 0001, 0010, 1000, each separated by >=1 idle cycle.
REQ-034 raa[0]=8 in REQ, ACT bank 0 on the grant edge -> raa[0]=1, rfm_cmd=4'b0001.
REQ-035 rstn=0 for one edge while rfm_req=1 -> rfm_req=0, all raa=0, no rfm_cmd pulse; next 8 ACTs to bank 3 restart normally with rfm_bank=3.
REQ-036 rfm_gnt pulsed while IDLE with no pending -> no state change, rfm_cmd stays 0.
